color_fsm_driver: RTL and testbench

COLOR_FSM_DRIVER -- requirements
Module: color_fsm_driver

---
 rtl/color_fsm_driver_pkg.sv | 54 +++++
 rtl/color_fsm_driver_lut.sv | 36 +++
 rtl/color_fsm_driver.sv | 121 ++++++++++++
 tb/tb_color_fsm_driver.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/color_fsm_driver_pkg.sv
// color_fsm_driver_pkg
//   Types and constants shared by the Color FSM driver and its path lookup.
//   - color_state_e : Color state machine encoding (same encoding as the Color FSM)
//   - drv_state_e   : driver control FSM states
//   - CMD_*         : codes driven on the Color FSM "in" input (3 = hold)
//   - exp_obs()     : output the Color FSM shows in each state
//   - next_color()  : Color FSM transition function, used to advance the shadow
package color_fsm_driver_pkg;

  typedef enum logic [1:0] {
    BLUE     = 2'd0,
    RED      = 2'd1,
    HSV_IDLE = 2'd2
  } color_state_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEP1  = 3'd1,
    S_STEP2  = 3'd2,
    S_CHECK  = 3'd3,
    S_REPORT = 3'd4
  } drv_state_e;

  localparam logic [1:0] CMD_IN0  = 2'd0;
  localparam logic [1:0] CMD_IN1  = 2'd1;
  localparam logic [1:0] CMD_IN2  = 2'd2;
  localparam logic [1:0] CMD_HOLD = 2'd3;

  localparam logic [1:0] TGT_ILLEGAL = 2'd3;

  // Red and HSV_idle share output code 2, so a check cannot tell them apart.
  function automatic logic [1:0] exp_obs(input color_state_e s);
    logic [1:0] o;
    o = 2'd2;
    if (s == BLUE) o = 2'd1;
    return o;
  endfunction

  function automatic color_state_e next_color(input color_state_e s, input logic [1:0] c);
    color_state_e n;
    n = s;
    case (s)
      BLUE:     if (c == CMD_IN1) n = RED;
      RED: begin
        if (c == CMD_IN1)      n = BLUE;
        else if (c == CMD_IN2) n = HSV_IDLE;
      end
      HSV_IDLE: if (c == CMD_IN0) n = RED;
      default:  n = RED;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/color_fsm_driver_lut.sv
// color_path_lut
//   Combinational path table: for the current Color state and a legal target,
//   gives the number of commands needed (0..2) and the commands themselves.
//   Ports:
//     cur_i    : current Color state (shadow)
//     tgt_i    : requested target code (3 is handled by the caller)
//     nsteps_o : number of move commands (0, 1 or 2)
//     c1_o     : first command
//     c2_o     : second command (hold when unused)
module color_path_lut
  import color_fsm_driver_pkg::*;
(
  input  color_state_e cur_i,
  input  logic [1:0]   tgt_i,
  output logic [1:0]   nsteps_o,
  output logic [1:0]   c1_o,
  output logic [1:0]   c2_o
);

  always_comb begin
    nsteps_o = 2'd0;
    c1_o     = CMD_HOLD;
    c2_o     = CMD_HOLD;
    case ({cur_i, tgt_i})
      {BLUE, 2'd1}:     begin nsteps_o = 2'd1; c1_o = CMD_IN1; end
      {RED, 2'd0}:      begin nsteps_o = 2'd1; c1_o = CMD_IN1; end
      {RED, 2'd2}:      begin nsteps_o = 2'd1; c1_o = CMD_IN2; end
      {HSV_IDLE, 2'd1}: begin nsteps_o = 2'd1; c1_o = CMD_IN0; end
      // No direct Blue<->HSV_idle arc: go through Red.
      {BLUE, 2'd2}:     begin nsteps_o = 2'd2; c1_o = CMD_IN1; c2_o = CMD_IN2; end
      {HSV_IDLE, 2'd0}: begin nsteps_o = 2'd2; c1_o = CMD_IN0; c2_o = CMD_IN1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/color_fsm_driver.sv
// color_fsm_driver
//   Drives the Color state machine to a requested state, keeps a shadow copy
//   of its state, and checks its output once the move has completed.
//   Ports:
//     clk, rst     : clock (rising edge) and async active-high reset (shared with Color FSM)
//     req_valid    : move request present
//     req_ready    : driver idle, request accepted when req_valid & req_ready
//     req_target   : target state (0 Blue, 1 Red, 2 HSV_idle, 3 illegal)
//     cmd          : registered command to the Color FSM "in" input (3 = hold)
//     obs          : Color FSM "out" fed back for checking
//     shadow_state : driver's model of the Color FSM state
//     done         : one-cycle pulse, move finished
//     err          : one-cycle pulse, illegal target or output mismatch
module color_fsm_driver
  import color_fsm_driver_pkg::*;
#(
  parameter int CHECK_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_target,
  output logic [1:0] cmd,
  input  logic [1:0] obs,
  output logic [1:0] shadow_state,
  output logic       done,
  output logic       err
);

  drv_state_e   state_q;
  color_state_e shadow_q;
  logic [1:0]   cmd_q;
  logic [1:0]   c2_q;
  logic         two_q;
  logic         done_q;
  logic         err_q;

  logic [1:0]   lut_nsteps;
  logic [1:0]   lut_c1;
  logic [1:0]   lut_c2;

  // Path is looked up from the live request; only its result is captured,
  // so later changes on req_target have no effect on a running move.
  color_path_lut u_lut (
    .cur_i    (shadow_q),
    .tgt_i    (req_target),
    .nsteps_o (lut_nsteps),
    .c1_o     (lut_c1),
    .c2_o     (lut_c2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shadow_q <= RED;
      cmd_q    <= CMD_HOLD;
      c2_q     <= CMD_HOLD;
      two_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_q <= CMD_HOLD;
          if (req_valid) begin
            if (req_target == TGT_ILLEGAL) begin
              // Rejected without leaving IDLE, so ready stays high.
              err_q <= 1'b1;
            end else if (lut_nsteps == 2'd0) begin
              state_q <= S_CHECK;
            end else begin
              cmd_q   <= lut_c1;
              c2_q    <= lut_c2;
              two_q   <= (lut_nsteps == 2'd2);
              state_q <= S_STEP1;
            end
          end
        end
        // The Color FSM samples cmd on this same edge, so the shadow moves with it.
        S_STEP1: begin
          shadow_q <= next_color(shadow_q, cmd_q);
          if (two_q) begin
            cmd_q   <= c2_q;
            state_q <= S_STEP2;
          end else begin
            cmd_q   <= CMD_HOLD;
            state_q <= S_CHECK;
          end
        end
        S_STEP2: begin
          shadow_q <= next_color(shadow_q, cmd_q);
          cmd_q    <= CMD_HOLD;
          state_q  <= S_CHECK;
        end
        // Shadow is never resynchronised from obs; a mismatch is only reported.
        S_CHECK: begin
          done_q  <= 1'b1;
          if ((CHECK_EN != 0) && (obs != exp_obs(shadow_q))) err_q <= 1'b1;
          state_q <= S_REPORT;
        end
        S_REPORT: begin
          state_q <= S_IDLE;
        end
        default: begin
          cmd_q   <= CMD_HOLD;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign cmd          = cmd_q;
  assign shadow_state = shadow_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_color_fsm_driver.sv
module tb_color_fsm_driver;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_target;
  logic       req_ready, req_ready_nc;
  logic [1:0] cmd, cmd_nc;
  logic [1:0] shadow_state, shadow_nc;
  logic       done, done_nc;
  logic       err, err_nc;
  logic [1:0] obs;
  logic       obs_force;
  logic [1:0] col;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] shadow;
    logic       err;
  } exp_t;
  exp_t sb_q[$];

  color_fsm_driver #(.CHECK_EN(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .cmd(cmd), .obs(obs),
    .shadow_state(shadow_state), .done(done), .err(err)
  );

  color_fsm_driver #(.CHECK_EN(0)) dut_nc (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_nc),
    .req_target(req_target), .cmd(cmd_nc), .obs(obs),
    .shadow_state(shadow_nc), .done(done_nc), .err(err_nc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Color FSM driven by the DUT command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) col <= 2'd1;
    else begin
      case (col)
        2'd0:    if (cmd == 2'd1) col <= 2'd1;
        2'd1: begin
          if (cmd == 2'd1)      col <= 2'd0;
          else if (cmd == 2'd2) col <= 2'd2;
        end
        2'd2:    if (cmd == 2'd0) col <= 2'd1;
        default: col <= 2'd1;
      endcase
    end
  end

  assign obs = obs_force ? 2'd1 : ((col == 2'd0) ? 2'd1 : 2'd2);

  task automatic chk(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Legal move: one request, then cycle-by-cycle checks until ready returns.
  task automatic run_move(input logic [1:0] tgt, input int nst,
                          input logic [1:0] c1, input logic [1:0] c2, input bit bad);
    exp_t e;
    int   exp_cmd;
    @(negedge clk);
    chk("ready_T", req_ready, 1);
    req_valid  = 1'b1;
    req_target = tgt;
    e.shadow = tgt;
    e.err    = bad;
    sb_q.push_back(e);
    for (int k = 1; k <= nst + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid  = 1'b0;
        req_target = 2'(tgt + 2'd1);
      end
      exp_cmd = 3;
      if (k == 1 && nst >= 1) exp_cmd = c1;
      if (k == 2 && nst == 2) exp_cmd = c2;
      chk($sformatf("cmd_t%0d_k%0d", tgt, k), cmd, exp_cmd);
      chk($sformatf("done_t%0d_k%0d", tgt, k), done, (k == nst + 2) ? 1 : 0);
      chk($sformatf("ready_t%0d_k%0d", tgt, k), req_ready, (k == nst + 3) ? 1 : 0);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb_q.pop_front();
          chk("sb_shadow", shadow_state, e.shadow);
          chk("sb_err", err, e.err);
          chk("target_fsm_state", col, tgt);
        end
        if (bad) begin
          chk("nc_err", err_nc, 0);
          chk("nc_done", done_nc, 1);
        end
      end else begin
        chk($sformatf("err_idle_k%0d", k), err, 0);
      end
      obs_force = bad && (k == nst + 1);
    end
    if (sb_q.size() != 0) begin
      chk("sb_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_target = 2'd0;
    obs_force  = 1'b0;
    #1;
    chk("rst_cmd", cmd, 3);
    chk("rst_shadow", shadow_state, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);

    run_move(2'd0, 1, 2'd1, 2'd3, 1'b0);   // Red -> Blue
    run_move(2'd2, 2, 2'd1, 2'd2, 1'b0);   // Blue -> HSV
    run_move(2'd0, 2, 2'd0, 2'd1, 1'b0);   // HSV -> Blue
    run_move(2'd1, 1, 2'd1, 2'd3, 1'b0);   // Blue -> Red
    run_move(2'd1, 0, 2'd3, 2'd3, 1'b0);   // Red -> Red
    run_move(2'd2, 1, 2'd2, 2'd3, 1'b0);   // Red -> HSV
    run_move(2'd2, 0, 2'd3, 2'd3, 1'b0);   // HSV -> HSV
    run_move(2'd1, 1, 2'd0, 2'd3, 1'b0);   // HSV -> Red

    // Illegal target
    @(negedge clk);
    req_valid  = 1'b1;
    req_target = 2'd3;
    @(negedge clk);
    req_valid  = 1'b0;
    req_target = 2'd0;
    chk("ill_err", err, 1);
    chk("ill_done", done, 0);
    chk("ill_ready", req_ready, 1);
    chk("ill_cmd", cmd, 3);
    chk("ill_shadow", shadow_state, 1);
    @(negedge clk);
    chk("ill_err_clr", err, 0);
    chk("ill_done2", done, 0);

    // Forced mismatch on a move into Red
    run_move(2'd0, 1, 2'd1, 2'd3, 1'b0);   // Red -> Blue
    run_move(2'd1, 1, 2'd1, 2'd3, 1'b1);   // Blue -> Red, obs forced to 1
    run_move(2'd0, 1, 2'd1, 2'd3, 1'b0);   // Red -> Blue

    // Reset in the middle of a two-step move
    @(negedge clk);
    req_valid  = 1'b1;
    req_target = 2'd2;
    @(negedge clk);
    req_valid  = 1'b0;
    chk("mr_cmd_k1", cmd, 1);
    @(negedge clk);
    chk("mr_cmd_k2", cmd, 2);
    rst = 1'b1;
    #1;
    chk("mr_cmd", cmd, 3);
    chk("mr_shadow", shadow_state, 1);
    chk("mr_done", done, 0);
    chk("mr_err", err, 0);
    @(negedge clk);
    chk("mr_done_held", done, 0);
    rst = 1'b0;
    run_move(2'd0, 1, 2'd1, 2'd3, 1'b0);   // Red -> Blue after reset
    run_move(2'd2, 2, 2'd1, 2'd2, 1'b0);   // Blue -> HSV

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
